data_cache: RTL and testbench

Direct-mapped, write-through, one-word-per-line data cache between the pipeline's memory stage and a multi-cycle backing data memory. It serves load hits in the same cycle. It stalls the pipeline on load misses and on every store while it runs a request/acknowledge transaction to backing memory. Word-level only: byte extraction for loads stays in the memory stage; store byte enables pass through.

---
 rtl/data_cache.sv | 138 +++++++++++++
 tb/tb_data_cache.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through word cache; defining DCACHE_STATS_EN adds hit/miss counters
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o,
`endif
    input  logic                  mem_ack_i
);
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                  r_state, w_next;
    logic [SETS-1:0]         r_valid;
    logic [TAG_BITS-1:0]     r_tag [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS];
    logic                    r_hit;
    logic                    r_mem_req, r_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem_addr, r_mem_wdata;
    logic [3:0]              r_mem_be;

    logic [INDEX_BITS-1:0]   w_idx, w_mem_idx;
    logic [TAG_BITS-1:0]     w_tag, w_mem_tag;
    logic                    w_hit, w_store, w_load, w_start;

    assign w_idx     = addr_i[INDEX_BITS+1:2];
    assign w_tag     = addr_i[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_mem_idx = r_mem_addr[INDEX_BITS+1:2];
    assign w_mem_tag = r_mem_addr[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store   = wr_en_i;
    assign w_load    = rd_en_i && !wr_en_i;
    assign w_start   = (r_state == IDLE) && (w_store || (w_load && !w_hit));

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;

    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        rd_data_o = '0;
        case (r_state)
            IDLE: begin
                stall_o   = w_store || (w_load && !w_hit);
                rd_data_o = (w_load && w_hit) ? r_data[w_idx] : '0;
                w_next    = w_store ? WRITE : (w_load && !w_hit) ? REFILL : IDLE;
            end
            REFILL: begin
                stall_o   = !mem_ack_i;
                rd_data_o = mem_ack_i ? mem_rdata_i : '0;
                w_next    = mem_ack_i ? IDLE : REFILL;
            end
            WRITE: begin
                stall_o = !mem_ack_i;
                w_next  = mem_ack_i ? IDLE : WRITE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_hit       <= 1'b0;
        end else if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_store;
            r_mem_addr  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
            r_mem_wdata <= w_store ? wr_data_i : '0;
            r_mem_be    <= w_store ? byte_en_i : 4'b1111;
            r_hit       <= w_hit;
        end else if (r_state != IDLE && mem_ack_i) begin
            r_mem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_valid <= '0;
        else if (r_state == REFILL && mem_ack_i) r_valid[w_mem_idx] <= 1'b1;
    end

    // Store data merges only into a line that hit when the store was latched: no write-allocate.
    always_ff @(posedge clk) begin
        if (!rst && r_state == REFILL && mem_ack_i) begin
            r_tag[w_mem_idx]  <= w_mem_tag;
            r_data[w_mem_idx] <= mem_rdata_i;
        end else if (!rst && r_state == WRITE && mem_ack_i && r_hit) begin
            for (int b = 0; b < 4; b++)
                if (r_mem_be[b]) r_data[w_mem_idx][8*b +: 8] <= r_mem_wdata[8*b +: 8];
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count, r_miss_count;
    assign hit_count_o  = r_hit_count;
    assign miss_count_o = r_miss_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == IDLE && w_load) begin
            if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
            else       r_miss_count <= r_miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scenarios plus randomized traffic against a line-level cache/memory model
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en_i = 1'b0, wr_en_i = 1'b0;
    logic [31:0] addr_i = '0, wr_data_i = '0;
    logic [3:0]  byte_en_i = '0;
    logic [31:0] rd_data_o;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    int n_checks = 0;
    int n_fail = 0;

    data_cache dut (
        .clk(clk), .rst(rst), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i), .addr_i(addr_i),
        .wr_data_i(wr_data_i), .byte_en_i(byte_en_i), .rd_data_o(rd_data_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
`ifdef DCACHE_STATS_EN
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
`endif
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: backing memory as a sparse word map; each line remembers the full word address it holds.
    logic [31:0] bmem [logic [29:0]];
    bit          ref_valid [256];
    logic [29:0] ref_word  [256];
    logic [31:0] ref_data  [256];

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return bmem.exists(w) ? bmem[w] : {w[15:0], ~w[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_valid[i] = 0;
    endtask

    task automatic model_access(input bit wr, input logic [29:0] w, input logic [31:0] wd,
                                input logic [3:0] be, output bit hit, output logic [31:0] exp);
        int idx = int'(w % 256);
        hit = ref_valid[idx] && ref_word[idx] == w;
        exp = '0;
        if (wr) begin
            bmem[w] = merge(mem_word(w), wd, be);
            if (hit) ref_data[idx] = merge(ref_data[idx], wd, be);
        end else begin
            exp = hit ? ref_data[idx] : mem_word(w);
            if (!hit) begin
                ref_valid[idx] = 1;
                ref_word[idx]  = w;
                ref_data[idx]  = exp;
            end
        end
    endtask

    task automatic run_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int k, input logic [31:0] ack_data,
                          output int stalls, output logic [31:0] rdata, output logic req1,
                          output logic we1, output logic [31:0] addr1, output logic [31:0] wdata1,
                          output logic [3:0] be1, output logic ack_stall, output logic req_after);
        @(negedge clk);
        rd_en_i = rd; wr_en_i = wr; addr_i = a; wr_data_i = wd; byte_en_i = be;
        #1;
        stalls = 0; rdata = rd_data_o; req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
        ack_stall = 0;
        if (stall_o) begin
            stalls = 1;
            for (int c = 1; c <= k; c++) begin
                @(negedge clk);
                if (c == k) begin mem_ack_i = 1'b1; mem_rdata_i = ack_data; end
                #1;
                if (c == 1) begin
                    req1 = mem_req_o; we1 = mem_we_o; addr1 = mem_addr_o;
                    wdata1 = mem_wdata_o; be1 = mem_be_o;
                end
                if (c == k) begin rdata = rd_data_o; ack_stall = stall_o; end
                else if (stall_o) stalls++;
            end
        end
        @(negedge clk);
        mem_ack_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
        #1;
        req_after = mem_req_o;
    endtask

    int st; logic [31:0] rdat, a1, wd1; logic rq1, we1, ast, rqa; logic [3:0] be1;
    bit hit; logic [31:0] exp;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks += 7;
        if (stall_o !== 1'b0)     begin n_fail++; $display("FAIL reset_stall got=%0b want=0", stall_o); end
        if (mem_req_o !== 1'b0)   begin n_fail++; $display("FAIL reset_req got=%0b want=0", mem_req_o); end
        if (mem_we_o !== 1'b0)    begin n_fail++; $display("FAIL reset_we got=%0b want=0", mem_we_o); end
        if (mem_addr_o !== '0)    begin n_fail++; $display("FAIL reset_addr got=%h want=0", mem_addr_o); end
        if (mem_wdata_o !== '0)   begin n_fail++; $display("FAIL reset_wdata got=%h want=0", mem_wdata_o); end
        if (mem_be_o !== 4'b0000) begin n_fail++; $display("FAIL reset_be got=%b want=0", mem_be_o); end
        if (rd_data_o !== '0)     begin n_fail++; $display("FAIL reset_rdata got=%h want=0", rd_data_o); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_load();
        bmem[30'h40] = 32'hDEADBEEF;
        model_access(0, 30'h40, '0, '0, hit, exp);
        run_op(0, 1, 32'h100, '0, '0, 3, exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 8;
        if (st !== 3)             begin n_fail++; $display("FAIL cold_stalls got=%0d want=3", st); end
        if (rq1 !== 1'b1)         begin n_fail++; $display("FAIL cold_req got=%0b want=1", rq1); end
        if (a1 !== 32'h100)       begin n_fail++; $display("FAIL cold_addr got=%h want=100", a1); end
        if (we1 !== 1'b0)         begin n_fail++; $display("FAIL cold_we got=%0b want=0", we1); end
        if (be1 !== 4'b1111)      begin n_fail++; $display("FAIL cold_be got=%b want=1111", be1); end
        if (rdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cold_rdata got=%h want=deadbeef", rdat); end
        if (ast !== 1'b0)         begin n_fail++; $display("FAIL cold_ack_stall got=%0b want=0", ast); end
        if (rqa !== 1'b0)         begin n_fail++; $display("FAIL cold_req_drop got=%0b want=0", rqa); end
        model_access(0, 30'h40, '0, '0, hit, exp);
        run_op(0, 1, 32'h100, '0, '0, 1, 32'h0, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 0)              begin n_fail++; $display("FAIL hit_stalls got=%0d want=0", st); end
        if (rdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rdata got=%h want=deadbeef", rdat); end
`ifdef DCACHE_STATS_EN
        n_checks += 2;
        if (miss_count_o !== 32'd1) begin n_fail++; $display("FAIL stats_miss got=%0d want=1", miss_count_o); end
        if (hit_count_o !== 32'd1)  begin n_fail++; $display("FAIL stats_hit got=%0d want=1", hit_count_o); end
`endif
    endtask

    task automatic test_store_hit();
        model_access(1, 30'h40, 32'hAA, 4'b0001, hit, exp);
        run_op(1, 0, 32'h100, 32'hAA, 4'b0001, 1, 32'h0, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 5;
        if (st !== 1)         begin n_fail++; $display("FAIL st_hit_stalls got=%0d want=1", st); end
        if (we1 !== 1'b1)     begin n_fail++; $display("FAIL st_hit_we got=%0b want=1", we1); end
        if (be1 !== 4'b0001)  begin n_fail++; $display("FAIL st_hit_be got=%b want=0001", be1); end
        if (wd1 !== 32'hAA)   begin n_fail++; $display("FAIL st_hit_wdata got=%h want=aa", wd1); end
        if (a1 !== 32'h100)   begin n_fail++; $display("FAIL st_hit_addr got=%h want=100", a1); end
        model_access(0, 30'h40, '0, '0, hit, exp);
        run_op(0, 1, 32'h100, '0, '0, 1, 32'h0, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 0)              begin n_fail++; $display("FAIL st_hit_load_stalls got=%0d want=0", st); end
        if (rdat !== 32'hDEADBEAA) begin n_fail++; $display("FAIL st_hit_merge got=%h want=deadbeaa", rdat); end
    endtask

    task automatic test_store_miss();
        model_access(1, 30'h80, 32'h11223344, 4'b1111, hit, exp);
        run_op(1, 1, 32'h200, 32'h11223344, 4'b1111, 2, 32'h0, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 2)     begin n_fail++; $display("FAIL st_miss_stalls got=%0d want=2", st); end
        if (we1 !== 1'b1) begin n_fail++; $display("FAIL st_both_we got=%0b want=1", we1); end
        model_access(0, 30'h80, '0, '0, hit, exp);
        run_op(0, 1, 32'h200, '0, '0, 2, exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 2)              begin n_fail++; $display("FAIL no_alloc_stalls got=%0d want=2", st); end
        if (rdat !== 32'h11223344) begin n_fail++; $display("FAIL no_alloc_rdata got=%h want=11223344", rdat); end
    endtask

    task automatic test_conflict();
        model_access(0, 30'h140, '0, '0, hit, exp);
        run_op(0, 1, 32'h500, '0, '0, 2, exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        model_access(0, 30'h40, '0, '0, hit, exp);
        run_op(0, 1, 32'h100, '0, '0, 2, exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 2)              begin n_fail++; $display("FAIL conflict_stalls got=%0d want=2", st); end
        if (rdat !== 32'hDEADBEAA) begin n_fail++; $display("FAIL conflict_rdata got=%h want=deadbeaa", rdat); end
    endtask

    task automatic test_reset_refill();
        @(negedge clk);
        rd_en_i = 1'b1; addr_i = 32'h700;
        repeat (2) @(negedge clk);
        rst = 1'b1; rd_en_i = 1'b0;
        @(negedge clk);
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        #1;
        n_checks += 3;
        if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req got=%0b want=0", mem_req_o); end
        if (stall_o !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_stall got=%0b want=0", stall_o); end
        if (rd_data_o !== '0)   begin n_fail++; $display("FAIL rst_mid_rdata got=%h want=0", rd_data_o); end
        @(negedge clk);
        mem_ack_i = 1'b0;
        model_clear();
        model_access(0, 30'h1C0, '0, '0, hit, exp);
        run_op(0, 1, 32'h700, '0, '0, 2, exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
        n_checks += 2;
        if (st !== 2)     begin n_fail++; $display("FAIL rst_late_ack_stalls got=%0d want=2", st); end
        if (rdat !== exp) begin n_fail++; $display("FAIL rst_late_ack_rdata got=%h want=%h", rdat, exp); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit          wr = ($urandom % 3) == 0;
            bit          rd = wr ? bit'($urandom % 2) : 1'b1;
            logic [29:0] w = 30'(($urandom % 3) * 256 + ($urandom % 8));
            logic [31:0] a = {w, 2'($urandom)};
            logic [31:0] wd = $urandom;
            logic [3:0]  be = 4'($urandom);
            int          k = int'($urandom_range(1, 4));
            model_access(wr, w, wd, be, hit, exp);
            run_op(wr, rd, a, wd, be, k, wr ? $urandom : exp, st, rdat, rq1, we1, a1, wd1, be1, ast, rqa);
            n_checks += 2;
            if (st !== ((wr || !hit) ? k : 0)) begin n_fail++; $display("FAIL rnd_stalls i=%0d got=%0d want=%0d", i, st, (wr || !hit) ? k : 0); end
            if (rqa !== 1'b0) begin n_fail++; $display("FAIL rnd_req_drop i=%0d got=%0b want=0", i, rqa); end
            if (wr) begin
                n_checks += 3;
                if (a1 !== {w, 2'b00}) begin n_fail++; $display("FAIL rnd_st_addr i=%0d got=%h want=%h", i, a1, {w, 2'b00}); end
                if (wd1 !== wd)        begin n_fail++; $display("FAIL rnd_st_wdata i=%0d got=%h want=%h", i, wd1, wd); end
                if (be1 !== be)        begin n_fail++; $display("FAIL rnd_st_be i=%0d got=%b want=%b", i, be1, be); end
            end else begin
                n_checks++;
                if (rdat !== exp) begin n_fail++; $display("FAIL rnd_ld_rdata i=%0d got=%h want=%h", i, rdat, exp); end
                if (!hit) begin
                    n_checks += 2;
                    if (a1 !== {w, 2'b00}) begin n_fail++; $display("FAIL rnd_ld_addr i=%0d got=%h want=%h", i, a1, {w, 2'b00}); end
                    if (be1 !== 4'b1111)   begin n_fail++; $display("FAIL rnd_ld_be i=%0d got=%b want=1111", i, be1); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
